// File: rtl/execute_muldiv_pkg.sv
// Shared types for the execute stage.
//   common : machine word and small counter types, sign-extension helper.
//   pipes  : op encoding, decode/execute stage bundles, mul/div FSM states
//            and op-classification helpers.

package common;
  typedef logic [63:0] word_t;
  typedef logic [5:0]  u6;
  typedef logic [6:0]  u7;

  function automatic word_t sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

package pipes;
  import common::*;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_LOAD, OP_STORE,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [31:0] instr;
    word_t       srca;
    word_t       srcb;
    word_t       rd;
  } decode_data_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [31:0] instr;
    word_t       aluout;
    word_t       rd;
  } exec_data_t;

  function automatic logic is_muldiv(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic md_is_div(input op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic md_is_quot(input op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW};
  endfunction

  function automatic logic md_is_word(input op_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic md_signed_a(input op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic md_signed_b(input op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction
endpackage

// File: rtl/execute_muldiv_muldiv.sv
// Iterative RV64M multiply/divide unit.
//   clk, rst_n        : clock, async active-low reset
//   flush             : abort/squash, highest priority
//   stall_in          : holds DONE while downstream is stalled
//   start, op         : a mul/div op is presented on the inputs
//   srca, srcb        : operands, sampled only on the IDLE -> BUSY/DONE edge
//   done              : result_q is valid
//   result            : registered result
//
// state | meaning
// IDLE  | waiting for a mul/div op
// BUSY  | 64 shift-add / restoring-divide iterations in progress
// DONE  | result_q valid, held while stall_in is high

module muldiv_unit
  import common::*;
  import pipes::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  stall_in,
  input  logic  start,
  input  op_t   op,
  input  word_t srca,
  input  word_t srcb,
  output logic  done,
  output word_t result
);

  muldiv_state_t state_q, state_d;
  u7     cnt_q, cnt_d;
  op_t   op_q, op_d;
  logic  neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  word_t a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  word_t hi_q, hi_d, lo_q, lo_d;
  word_t result_q, result_d;

  // Operand preparation for the op currently on the inputs.
  logic  sa, sb, neg_a, neg_b, is_div, div_zero, div_ovf;
  word_t a_ext, b_ext, a_mag, b_mag, sp_q, sp_r, special_res;

  always_comb begin
    sa = md_signed_a(op);
    sb = md_signed_b(op);
    if (md_is_word(op)) begin
      a_ext = sa ? sext32(srca[31:0]) : {32'b0, srca[31:0]};
      b_ext = sb ? sext32(srcb[31:0]) : {32'b0, srcb[31:0]};
    end else begin
      a_ext = srca;
      b_ext = srcb;
    end
    neg_a  = sa & a_ext[63];
    neg_b  = sb & b_ext[63];
    a_mag  = neg_a ? -a_ext : a_ext;
    b_mag  = neg_b ? -b_ext : b_ext;
    is_div = md_is_div(op);
    div_zero = is_div && (b_ext == '0);
    // Most-negative value of the operand width, seen after sign extension.
    div_ovf  = is_div && sa && (b_ext == '1) &&
               (a_ext == (md_is_word(op) ? 64'hFFFF_FFFF_8000_0000
                                         : 64'h8000_0000_0000_0000));
    sp_q = div_zero ? '1 : a_ext;
    sp_r = div_zero ? a_ext : '0;
    special_res = md_is_quot(op) ? sp_q : sp_r;
    if (md_is_word(op)) special_res = sext32(special_res[31:0]);
  end

  // One iteration. hi/lo hold {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [64:0] mul_sum, div_shift;
  logic        div_ge;
  word_t       hi_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : 65'd0);
    div_shift = {hi_q, lo_q[63]};
    div_ge    = div_shift >= {1'b0, b_mag_q};
    if (md_is_div(op_q)) begin
      // When div_ge the difference is below the divisor, so the low 64 bits are exact.
      hi_step = div_ge ? (div_shift[63:0] - b_mag_q) : div_shift[63:0];
      lo_step = {lo_q[62:0], div_ge};
    end else begin
      hi_step = mul_sum[64:1];
      lo_step = {mul_sum[0], lo_q[63:1]};
    end
  end

  // Sign fix-up and result selection from the final iteration.
  logic [127:0] prod;
  word_t        quo, rem, fin_res;

  always_comb begin
    prod = {hi_step, lo_step};
    if (neg_a_q ^ neg_b_q) prod = ~prod + 128'd1;
    quo = (neg_a_q ^ neg_b_q) ? -lo_step : lo_step;
    rem = neg_a_q ? -hi_step : hi_step;
    fin_res = md_is_quot(op_q) ? quo : rem;
    if (md_is_word(op_q)) fin_res = sext32(fin_res[31:0]);
    case (op_q)
      OP_MUL:                       fin_res = prod[63:0];
      OP_MULH, OP_MULHU, OP_MULHSU: fin_res = prod[127:64];
      OP_MULW:                      fin_res = sext32(prod[31:0]);
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          neg_a_d = neg_a;
          neg_b_d = neg_b;
          a_mag_d = a_mag;
          b_mag_d = b_mag;
          hi_d    = '0;
          lo_d    = is_div ? a_mag : b_mag;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            // 63 down to 0 inclusive: 64 iterations, last one at count 0.
            cnt_d   = 7'd63;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          hi_d = hi_step;
          lo_d = lo_step;
          if (cnt_q == '0) begin
            result_d = fin_res;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
      end
      DONE: begin
        if (flush || !stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle integer ALU plus iterative RV64M unit.
//   clk       : rising-edge clock
//   reset     : async active-low reset
//   flush     : squash in-flight instruction, aborts mul/div
//   stall_in  : downstream hold; a finished mul/div result stays in DONE
//   dataD     : decoded instruction bundle
//   dataE     : execute bundle, ctl/dst/instr/rd passed through
//   exec_busy : mul/div result not yet available

module execute_muldiv
  import common::*;
  import pipes::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall_in,
  input  decode_data_t dataD,
  output exec_data_t   dataE,
  output logic         exec_busy
);

  word_t       a, b, alu_out, md_result;
  logic [31:0] w32;
  u6           shamt;
  logic        md_op, md_done;

  assign a     = dataD.srca;
  assign b     = dataD.srcb;
  assign md_op = is_muldiv(dataD.ctl.op);

  always_comb begin
    alu_out = '0;
    w32     = '0;
    shamt   = b[5:0];
    case (dataD.ctl.op)
      OP_ADD, OP_LOAD, OP_STORE: alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_XOR:  alu_out = a ^ b;
      OP_SLL:  alu_out = a << shamt;
      OP_SRL:  alu_out = a >> shamt;
      OP_SRA:  alu_out = word_t'($signed(a) >>> shamt);
      OP_SLT:  alu_out = {63'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu_out = {63'b0, a < b};
      OP_ADDW: begin w32 = a[31:0] + b[31:0];   alu_out = sext32(w32); end
      OP_SUBW: begin w32 = a[31:0] - b[31:0];   alu_out = sext32(w32); end
      OP_SLLW: begin w32 = a[31:0] << b[4:0];   alu_out = sext32(w32); end
      OP_SRLW: begin w32 = a[31:0] >> b[4:0];   alu_out = sext32(w32); end
      OP_SRAW: begin
        w32     = 32'($signed(a[31:0]) >>> b[4:0]);
        alu_out = sext32(w32);
      end
      default: ;
    endcase
  end

  muldiv_unit u_muldiv (
    .clk     (clk),
    .rst_n   (reset),
    .flush   (flush),
    .stall_in(stall_in),
    .start   (md_op),
    .op      (dataD.ctl.op),
    .srca    (a),
    .srcb    (b),
    .done    (md_done),
    .result  (md_result)
  );

  assign exec_busy = md_op && !md_done;

  always_comb begin
    dataE        = '0;
    dataE.ctl    = dataD.ctl;
    dataE.dst    = dataD.dst;
    dataE.instr  = dataD.instr;
    dataE.rd     = dataD.rd;
    dataE.aluout = md_op ? md_result : alu_out;
  end

endmodule
